// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter.
//   meas_state_t    : measurement FSM state encoding
//   DEF_CNT_W       : default period/high-time counter width
//   DEF_TIMEOUT_CYC : default stall threshold in clock_in cycles (2 s at 50 MHz)
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } meas_state_t;

  localparam int unsigned DEF_CNT_W       = 28;
  localparam int unsigned DEF_TIMEOUT_CYC = 100_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous signal into the clock_in domain and flags its edges.
//   clock_in : sampling clock
//   rst_n    : asynchronous active-low reset
//   sig_in   : asynchronous input
//   level    : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_det (
  input  logic clock_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, hist;

  // meta/sync form the two-flop synchronizer; hist holds the previous
  // synchronized level so edges are a compare of two settled flops.
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= sig_in;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of sig_in in clock_in cycles.
//   clock_in     : measuring clock (50 MHz nominal)
//   rst_n        : asynchronous active-low reset (deassertion synchronized externally)
//   sig_in       : measured signal, asynchronous to clock_in
//   period_count : last rise-to-rise distance, saturating
//   high_count   : last high time, saturating
//   meas_valid   : one-cycle pulse when period_count/high_count update
//   no_clk       : high while sig_in has shown no rise for TIMEOUT_CYC cycles
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             meas_valid,
  output logic             no_clk
);

  // Wide enough to hold both the counter and the threshold, so a narrow
  // counter is never compared against a truncated threshold.
  localparam int unsigned TW = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  meas_state_t     state;
  logic [CNT_W-1:0] per_cnt, hi_cnt, hi_lat;
  logic            fell;
  logic            level, rise, fall;
  logic            timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sync_edge_det u_sync (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  assign timeout_hit = (TW'(per_cnt) == TO_LAST);

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      hi_lat       <= '0;
      fell         <= 1'b0;
      period_count <= '0;
      high_count   <= '0;
      meas_valid   <= 1'b0;
      no_clk       <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          // First rise only opens the window; nothing to report yet.
          if (rise) begin
            state   <= MEASURE;
            per_cnt <= '0;
            hi_cnt  <= '0;
            fell    <= 1'b0;
          end
        end

        MEASURE: begin
          // Rise has priority over the timeout when both land together.
          if (rise) begin
            period_count <= sat_inc(per_cnt);
            // Without a fall in this period the signal was high throughout.
            high_count   <= fell ? hi_lat : sat_inc(per_cnt);
            meas_valid   <= 1'b1;
            per_cnt      <= '0;
            hi_cnt       <= '0;
            fell         <= 1'b0;
          end else if (timeout_hit) begin
            state  <= STALL;
            no_clk <= 1'b1;
          end else begin
            per_cnt <= sat_inc(per_cnt);
            if (level) hi_cnt <= sat_inc(hi_cnt);
            // The fall cycle is already low; +1 accounts for the rise cycle.
            if (fall) begin
              hi_lat <= sat_inc(hi_cnt);
              fell   <= 1'b1;
            end
          end
        end

        STALL: begin
          // Partial period before the stall is dropped; start fresh.
          if (rise) begin
            state   <= MEASURE;
            no_clk  <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
            fell    <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: a 28-bit instance (a) and a 4-bit instance (b),
// both with a 64-cycle stall threshold. Stimulus waveforms feed a reference
// model that pushes expected measurements; meas_valid pops and compares.
module tb_clk_freq_meter;

  localparam int TO = 64;

  logic        clock_in = 1'b0;
  logic        rst_n;
  logic        sig_a, sig_b;
  logic [27:0] per_a, hi_a;
  logic        mv_a, nc_a;
  logic [3:0]  per_b, hi_b;
  logic        mv_b, nc_b;

  always #10 clock_in = ~clock_in;

  clk_freq_meter #(.CNT_W(28), .TIMEOUT_CYC(TO)) dut_a (
    .clock_in(clock_in), .rst_n(rst_n), .sig_in(sig_a),
    .period_count(per_a), .high_count(hi_a), .meas_valid(mv_a), .no_clk(nc_a)
  );

  clk_freq_meter #(.CNT_W(4), .TIMEOUT_CYC(TO)) dut_b (
    .clock_in(clock_in), .rst_n(rst_n), .sig_in(sig_b),
    .period_count(per_b), .high_count(hi_b), .meas_valid(mv_b), .no_clk(nc_b)
  );

  typedef struct {
    int unsigned per;
    int unsigned hi;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          total = 0, bad = 0, cyc = 0, last_mv0 = 0;
  bit          have[2], prev[2];
  int unsigned mper[2], mhi[2];
  bit          nc0_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int unsigned sat4(input int unsigned x);
    return (x > 15) ? 15 : x;
  endfunction

  // Reference model on the driven waveform: rise-to-rise tick distance and
  // high ticks per period; synchronizer delay is common to all edges.
  task automatic model_step(input int c, input bit v);
    exp_t e;
    if (v && !prev[c]) begin
      if (have[c]) begin
        e.per = (c == 1) ? sat4(mper[c]) : mper[c];
        e.hi  = (c == 1) ? sat4(mhi[c])  : mhi[c];
        if (c == 0) q0.push_back(e); else q1.push_back(e);
      end
      have[c] = 1'b1;
      mper[c] = 1;
      mhi[c]  = 1;
    end else if (have[c]) begin
      mper[c]++;
      if (v) mhi[c]++;
      // Only instance a can reach the threshold; b's counter stops at 15.
      if (c == 0 && mper[c] > TO) have[c] = 1'b0;
    end
    prev[c] = v;
  endtask

  task automatic tick(input bit va, input bit vb);
    exp_t e;
    sig_a = va;
    sig_b = vb;
    @(posedge clock_in);
    #1;
    cyc++;
    model_step(0, va);
    model_step(1, vb);
    nc0_seen |= nc_a;
    if (mv_a) begin
      last_mv0 = cyc;
      check("a_mv_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("a_period", 32'(per_a), e.per);
        check("a_high", 32'(hi_a), e.hi);
      end
    end
    if (mv_b) begin
      check("b_mv_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("b_period", 32'(per_b), e.per);
        check("b_high", 32'(hi_b), e.hi);
      end
    end
  endtask

  task automatic run_wave(input int c, input int period, input int high, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < period; j++)
        tick((c == 0) && (j < high), (c == 1) && (j < high));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_per_a"}, 32'(per_a), 0);
    check({tag, "_hi_a"}, 32'(hi_a), 0);
    check({tag, "_mv_a"}, 32'(mv_a), 0);
    check({tag, "_nc_a"}, 32'(nc_a), 0);
    check({tag, "_per_b"}, 32'(per_b), 0);
    check({tag, "_mv_b"}, 32'(mv_b), 0);
  endtask

  initial begin
    bit found;
    int dly, base;

    rst_n = 1'b0;
    sig_a = 1'b0;
    sig_b = 1'b0;
    #5;
    check_zero("reset");
    @(negedge clock_in);
    rst_n = 1'b1;

    // 50% duty /10, then /3 with 1 high; the seam period is also measured.
    run_wave(0, 10, 5, 6);
    run_wave(0, 3, 1, 6);

    // Rises exactly 64 apart: coincide with the threshold, rise wins.
    nc0_seen = 1'b0;
    run_wave(0, 64, 32, 3);
    check("coincide_no_stall", 32'(nc0_seen), 0);

    // Hold low: stall exactly 64 cycles after the last reported rise.
    found = 1'b0;
    dly   = 0;
    base  = last_mv0;
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 1'b0);
      if (nc_a === 1'b1 && !found) begin
        found = 1'b1;
        dly   = cyc - base;
      end
    end
    check("stall_seen", 32'(found), 1);
    check("stall_delay", 32'(dly), 64);
    check("stall_hold_per", 32'(per_a), 64);
    check("stall_hold_hi", 32'(hi_a), 32);

    // Restart: first rise clears no_clk, first report one period later.
    run_wave(0, 10, 5, 1);
    check("restart_nc", 32'(nc_a), 0);
    run_wave(0, 10, 5, 3);

    // Reset in the middle of a low phase.
    run_wave(0, 10, 5, 2);
    hold(3);
    check("pre_reset_queue", 32'(q0.size()), 0);
    @(negedge clock_in);
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clock_in);
    rst_n   = 1'b1;
    have[0] = 1'b0;
    have[1] = 1'b0;
    run_wave(0, 10, 5, 4);

    // 4-bit instance, 20-cycle period: saturates at 15.
    run_wave(1, 20, 10, 4);
    hold(10);
    check("b_no_stall", 32'(nc_b), 0);
    check("end_queue_a", 32'(q0.size()), 0);
    check("end_queue_b", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 28: width of the period and high-time counters.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100_000_000: number of clock_in cycles without a rising edge before no_clk asserts (2 s at 50 MHz).
REQ-003 The block SHALL have port clock_in, input, 1 bit: single system clock, 50 MHz nominal; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sig_in, input, 1 bit: measured clock (e.g. a divided clock), asynchronous to clock_in.
REQ-006 The block SHALL have port period_count, output, CNT_W bits: last measured period, in clock_in cycles.
REQ-007 The block SHALL have port high_count, output, CNT_W bits: last measured high time, in clock_in cycles.
REQ-008 The block SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period_count and high_count update.
REQ-009 The block SHALL have port no_clk, output, 1 bit: level, asserted while sig_in is stalled.

Function
REQ-010 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; rise = sync & ~hist, fall = ~sync & hist; detection latency 3 clock_in cycles after the sig_in edge.
REQ-011 The FSM SHALL have states IDLE, MEASURE and STALL.
REQ-012 IDLE: wait for the first rise -> MEASURE, clear per_cnt and hi_cnt, no meas_valid pulse.
REQ-013 MEASURE: per_cnt SHALL increment every cycle and restart at 0 on the cycle after a rise; at a rise, period_count <= per_cnt+1, so rises N cycles apart give period_count = N.
REQ-014 MEASURE: hi_cnt SHALL restart at a rise and count while the synchronized level is high; at a fall, hi_lat <= hi_cnt+1. At the next rise, high_count <= hi_lat.
REQ-015 meas_valid SHALL pulse high for exactly 1 cycle, on the cycle after each rise in MEASURE; outputs SHALL hold between updates.
REQ-016 Counters SHALL saturate at all-ones and never wrap.
REQ-017 MEASURE: when per_cnt reaches TIMEOUT_CYC-1 with no rise, the FSM SHALL go to STALL and set no_clk=1; no meas_valid; period_count and high_count hold.
REQ-018 STALL: on a rise, the FSM SHALL clear no_clk and go to MEASURE, restarting the counts; the partial period SHALL NOT be reported.
REQ-019 If a rise and the timeout coincide, the rise SHALL win: a normal measurement, no STALL.
REQ-020 A rise with no fall since the previous rise SHALL report high_count = period_count (constant-high case is impossible after sync; defensive only).

Reset
REQ-021 While rst_n=0, the block SHALL asynchronously clear: state=IDLE, synchronizer and history flops=0, per_cnt=hi_cnt=hi_lat=0, period_count=high_count=0, meas_valid=0, no_clk=0.
REQ-022 Deassertion of rst_n SHALL be synchronous to clock_in through a reset synchronizer external to the block; reset mid-measurement SHALL discard the partial period and resume from IDLE.

Structure
REQ-023 Package clk_meas_pkg SHALL hold the FSM state enum (IDLE, MEASURE, STALL) and the default CNT_W and TIMEOUT_CYC constants.
REQ-024 Sub-module sync_edge_det SHALL contain the 2-flop synchronizer, history flop and rise/fall outputs; clk_freq_meter SHALL instantiate it once.

Verification
REQ-025 clock_in 50 MHz, sig_in = clock_in/10 (50% duty): after 2nd rise, meas_valid every 10 cycles, period_count=10, high_count=5.
REQ-026 sig_in = clock_in/3 (1 high, 2 low): period_count=3, high_count=1.
REQ-027 TIMEOUT_CYC=64, sig_in held low after one measurement: no_clk=1 exactly 64 cycles after the last detected rise, outputs held; restart sig_in -> no_clk=0 at the next rise, first meas_valid one full period later.
REQ-028 Pulse rst_n low mid-period: all outputs 0 immediately; first meas_valid only after two rises post-reset.
REQ-029 CNT_W=4, period 20 cycles, TIMEOUT_CYC=64: period_count saturates at 15, no wrap.
REQ-030 Rise on the same cycle as the timeout threshold: meas_valid pulses, no_clk stays 0.
